// File: rtl/code_seg_pkg.sv
// -----------------------------------------------------------------------------
// code_seg_pkg
// Shared types and constants for the code_seg_display block.
//   - state_e  : debounce FSM states (IDLE, SETTLE, HOLD)
//   - SEG_0..F : active-low 7-segment patterns, bit order [7:0] = a,b,c,d,e,f,g,dp
//                (dp is always off, i.e. bit 0 is always 1)
//   - SEG_BLANK: all segments off
// -----------------------------------------------------------------------------
package code_seg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    localparam logic [7:0] SEG_0     = 8'h03;
    localparam logic [7:0] SEG_1     = 8'h9F;
    localparam logic [7:0] SEG_2     = 8'h25;
    localparam logic [7:0] SEG_3     = 8'h0D;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h49;
    localparam logic [7:0] SEG_6     = 8'h41;
    localparam logic [7:0] SEG_7     = 8'h1F;
    localparam logic [7:0] SEG_8     = 8'h01;
    localparam logic [7:0] SEG_9     = 8'h09;
    localparam logic [7:0] SEG_A     = 8'h11;
    localparam logic [7:0] SEG_B     = 8'hC1;
    localparam logic [7:0] SEG_C     = 8'h63;
    localparam logic [7:0] SEG_D     = 8'h85;
    localparam logic [7:0] SEG_E     = 8'h61;
    localparam logic [7:0] SEG_F     = 8'h71;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage : code_seg_pkg

// File: rtl/code_seg_display_hex_to_seg.sv
// -----------------------------------------------------------------------------
// hex_to_seg
// Combinational 4-bit hex to active-low 7-segment decoder.
// Ports:
//   hex_i   [3:0] value to display
//   blank_i       1 forces all segments off (SEG_BLANK)
//   seg_o   [7:0] active-low pattern, [7:0] = a,b,c,d,e,f,g,dp
// -----------------------------------------------------------------------------
module hex_to_seg
    import code_seg_pkg::*;
(
    input  logic [3:0] hex_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (hex_i)
                4'h0:    seg_o = SEG_0;
                4'h1:    seg_o = SEG_1;
                4'h2:    seg_o = SEG_2;
                4'h3:    seg_o = SEG_3;
                4'h4:    seg_o = SEG_4;
                4'h5:    seg_o = SEG_5;
                4'h6:    seg_o = SEG_6;
                4'h7:    seg_o = SEG_7;
                4'h8:    seg_o = SEG_8;
                4'h9:    seg_o = SEG_9;
                4'hA:    seg_o = SEG_A;
                4'hB:    seg_o = SEG_B;
                4'hC:    seg_o = SEG_C;
                4'hD:    seg_o = SEG_D;
                4'hE:    seg_o = SEG_E;
                default: seg_o = SEG_F;
            endcase
        end
    end

endmodule : hex_to_seg

// File: rtl/code_seg_display.sv
// -----------------------------------------------------------------------------
// code_seg_display
// Debounces the 3-bit code from the one-hot encoder stage, latches an accepted
// code onto a 7-segment digit and counts accepted changes (mod 16) on a second
// hex digit.
// Parameters:
//   STABLE_CYCLES  consecutive matching valid samples needed to commit (2..255)
//   CNT_W          stability counter width, 2**CNT_W > STABLE_CYCLES
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   code [2:0] encoded index from the encoder stage
//   code_vld   code qualifier; code is ignored while 0
//   seg0 [7:0] active-low pattern of the held code, blank until a commit
//   seg1 [7:0] active-low hex pattern of the change count
//   led_vld    1 once any code has been committed
//   chg_pulse  one-cycle strobe on each commit that changes the held value
// -----------------------------------------------------------------------------
module code_seg_display
    import code_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code,
    input  logic       code_vld,
    output logic [7:0] seg0,
    output logic [7:0] seg1,
    output logic       led_vld,
    output logic       chg_pulse
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Input stage: the FSM only ever looks at these registered copies.
    logic [2:0]       code_q;
    logic             vld_q;

    state_e           state_q,     state_d;
    logic [2:0]       cand_q,      cand_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [2:0]       held_q,      held_d;
    logic             held_vld_q,  held_vld_d;
    logic [3:0]       chg_cnt_q,   chg_cnt_d;
    logic             chg_pulse_q, chg_pulse_d;
    logic [7:0]       seg0_q,      seg0_d;
    logic [7:0]       seg1_q,      seg1_d;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        held_d      = held_q;
        held_vld_d  = held_vld_q;
        chg_cnt_d   = chg_cnt_q;
        chg_pulse_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (vld_q) begin
                    cand_d  = code_q;
                    cnt_d   = CNT_ONE;
                    state_d = SETTLE;
                end
            end

            SETTLE: begin
                if (!vld_q) begin
                    // Candidate abandoned; fall back to whatever is displayed.
                    state_d = held_vld_q ? HOLD : IDLE;
                end else if (code_q != cand_q) begin
                    // A new value restarts the run with this sample as #1.
                    cand_d = code_q;
                    cnt_d  = CNT_ONE;
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    held_d     = cand_q;
                    held_vld_d = 1'b1;
                    state_d    = HOLD;
                    // Re-committing the value already shown is silent.
                    if (!held_vld_q || (cand_q != held_q)) begin
                        chg_pulse_d = 1'b1;
                        chg_cnt_d   = chg_cnt_q + 4'd1;
                    end
                end
            end

            HOLD: begin
                if (vld_q && (code_q != held_q)) begin
                    cand_d  = code_q;
                    cnt_d   = CNT_ONE;
                    state_d = SETTLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Display decoders operate on next-state values so the segment outputs
    // update on the same edge as held/chg_cnt, not one cycle later.
    // -------------------------------------------------------------------------
    hex_to_seg u_seg0 (
        .hex_i   ({1'b0, held_d}),
        .blank_i (!held_vld_d),
        .seg_o   (seg0_d)
    );

    hex_to_seg u_seg1 (
        .hex_i   (chg_cnt_d),
        .blank_i (1'b0),
        .seg_o   (seg1_d)
    );

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q      <= 3'd0;
            vld_q       <= 1'b0;
            state_q     <= IDLE;
            cand_q      <= 3'd0;
            cnt_q       <= '0;
            held_q      <= 3'd0;
            held_vld_q  <= 1'b0;
            chg_cnt_q   <= 4'd0;
            chg_pulse_q <= 1'b0;
            seg0_q      <= SEG_BLANK;
            seg1_q      <= SEG_0;
        end else begin
            code_q      <= code;
            vld_q       <= code_vld;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            held_q      <= held_d;
            held_vld_q  <= held_vld_d;
            chg_cnt_q   <= chg_cnt_d;
            chg_pulse_q <= chg_pulse_d;
            seg0_q      <= seg0_d;
            seg1_q      <= seg1_d;
        end
    end

    assign seg0      = seg0_q;
    assign seg1      = seg1_q;
    assign led_vld   = held_vld_q;
    assign chg_pulse = chg_pulse_q;

endmodule : code_seg_display

// File: tb/tb_code_seg_display.sv
// -----------------------------------------------------------------------------
// tb_code_seg_display
// Scoreboard bench: every clock, the stimulus task feeds the same sample to a
// debounce reference (a run of STABLE identical valid samples commits the
// value) and pushes the expected outputs; each test task pops and compares.
// -----------------------------------------------------------------------------
module tb_code_seg_display;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] code = 3'd0;
    logic       code_vld = 1'b0;
    logic [7:0] seg0;
    logic [7:0] seg1;
    logic       led_vld;
    logic       chg_pulse;

    always #5 clk = ~clk;

    code_seg_display #(
        .STABLE_CYCLES (STABLE),
        .CNT_W         (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .code      (code),
        .code_vld  (code_vld),
        .seg0      (seg0),
        .seg1      (seg1),
        .led_vld   (led_vld),
        .chg_pulse (chg_pulse)
    );

    typedef struct {
        logic [7:0] seg0;
        logic [7:0] seg1;
        logic       led;
        logic       pulse;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] seg_tbl [16];

    int total = 0;
    int bad   = 0;

    // Reference state
    int m_held     = 0;
    bit m_held_vld = 1'b0;
    int m_cnt      = 0;
    bit m_pulse    = 1'b0;
    int run_code   = 0;
    int run_len    = 0;
    bit pend_vld   = 1'b0;
    int pend_code  = 0;

    // One sample of the debounce reference: consecutive identical valid
    // samples form a run; the run's STABLE-th sample commits its value.
    task automatic ref_sample(input bit v, input int c);
        m_pulse = 1'b0;
        if (!v) begin
            run_len = 0;
        end else begin
            if (run_len > 0 && c == run_code) run_len = run_len + 1;
            else begin
                run_code = c;
                run_len  = 1;
            end
            if (run_len == STABLE) begin
                if (!m_held_vld || c != m_held) begin
                    m_pulse = 1'b1;
                    m_cnt   = (m_cnt + 1) % 16;
                end
                m_held     = c;
                m_held_vld = 1'b1;
            end
        end
    endtask

    // Drive one clock of stimulus and push the outputs expected after it.
    // The design registers its inputs first, so a sample influences the
    // outputs one edge after it is captured.
    task automatic tick(input logic [2:0] c, input logic v, input logic r);
        exp_t e;
        code     = c;
        code_vld = v;
        rst      = r;
        @(posedge clk);
        if (r) begin
            m_held = 0; m_held_vld = 1'b0; m_cnt = 0; m_pulse = 1'b0;
            run_len = 0; pend_vld = 1'b0; pend_code = 0;
        end else begin
            ref_sample(pend_vld, pend_code);
            pend_vld  = v;
            pend_code = int'(c);
        end
        e.seg0  = m_held_vld ? seg_tbl[m_held] : 8'hFF;
        e.seg1  = seg_tbl[m_cnt];
        e.led   = m_held_vld;
        e.pulse = m_pulse;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            tick(3'd5, 1'b1, 1'b1);
            e = exp_q.pop_front();
            total++;
            if ({seg0, seg1, led_vld, chg_pulse} !== {8'hFF, 8'h03, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL reset cyc=%0d got seg0=%h seg1=%h led=%b pulse=%b want FF 03 0 0",
                         i, seg0, seg1, led_vld, chg_pulse);
            end
            total++;
            if ({seg0, seg1, led_vld, chg_pulse} !== {e.seg0, e.seg1, e.led, e.pulse}) begin
                bad++;
                $display("FAIL reset_sb cyc=%0d got %h %h %b %b want %h %h %b %b", i,
                         seg0, seg1, led_vld, chg_pulse, e.seg0, e.seg1, e.led, e.pulse);
            end
        end
    endtask

    task automatic test_clean_commit();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            tick(3'd3, 1'b1, 1'b0);
            e = exp_q.pop_front();
            total++;
            if ({seg0, seg1, led_vld, chg_pulse} !== {e.seg0, e.seg1, e.led, e.pulse}) begin
                bad++;
                $display("FAIL clean_sb cyc=%0d got %h %h %b %b want %h %h %b %b", i,
                         seg0, seg1, led_vld, chg_pulse, e.seg0, e.seg1, e.led, e.pulse);
            end
            total++;
            if (chg_pulse !== (i == 4)) begin
                bad++;
                $display("FAIL clean_pulse cyc=%0d got %b want %b", i, chg_pulse, (i == 4));
            end
        end
        total++;
        if ({seg0, seg1, led_vld} !== {8'h0D, 8'h9F, 1'b1}) begin
            bad++;
            $display("FAIL clean_final got seg0=%h seg1=%h led=%b want 0D 9F 1", seg0, seg1, led_vld);
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            tick((i < 3) ? 3'd6 : 3'd3, 1'b1, 1'b0);
            e = exp_q.pop_front();
            total++;
            if ({seg0, seg1, led_vld, chg_pulse} !== {e.seg0, e.seg1, e.led, e.pulse}) begin
                bad++;
                $display("FAIL glitch_sb cyc=%0d got %h %h %b %b want %h %h %b %b", i,
                         seg0, seg1, led_vld, chg_pulse, e.seg0, e.seg1, e.led, e.pulse);
            end
            total++;
            if ({seg0, seg1, chg_pulse} !== {8'h0D, 8'h9F, 1'b0}) begin
                bad++;
                $display("FAIL glitch_hold cyc=%0d got seg0=%h seg1=%h pulse=%b want 0D 9F 0",
                         i, seg0, seg1, chg_pulse);
            end
        end
    endtask

    task automatic test_mid_settle();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            tick((i < 2) ? 3'd2 : 3'd7, 1'b1, 1'b0);
            e = exp_q.pop_front();
            total++;
            if ({seg0, seg1, led_vld, chg_pulse} !== {e.seg0, e.seg1, e.led, e.pulse}) begin
                bad++;
                $display("FAIL midsettle_sb cyc=%0d got %h %h %b %b want %h %h %b %b", i,
                         seg0, seg1, led_vld, chg_pulse, e.seg0, e.seg1, e.led, e.pulse);
            end
            total++;
            if (chg_pulse !== (i == 6) || seg0 === 8'h25) begin
                bad++;
                $display("FAIL midsettle cyc=%0d got pulse=%b seg0=%h want pulse=%b seg0!=25",
                         i, chg_pulse, seg0, (i == 6));
            end
        end
        total++;
        if ({seg0, seg1} !== {8'h1F, 8'h25}) begin
            bad++;
            $display("FAIL midsettle_final got seg0=%h seg1=%h want 1F 25", seg0, seg1);
        end
    endtask

    task automatic test_valid_drop();
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            tick(3'd1, (i != 2), 1'b0);
            e = exp_q.pop_front();
            total++;
            if ({seg0, seg1, led_vld, chg_pulse} !== {e.seg0, e.seg1, e.led, e.pulse}) begin
                bad++;
                $display("FAIL vdrop_sb cyc=%0d got %h %h %b %b want %h %h %b %b", i,
                         seg0, seg1, led_vld, chg_pulse, e.seg0, e.seg1, e.led, e.pulse);
            end
            total++;
            if (chg_pulse !== (i == 7) || (i < 7 && seg0 !== 8'h1F)) begin
                bad++;
                $display("FAIL vdrop cyc=%0d got pulse=%b seg0=%h want pulse=%b", i,
                         chg_pulse, seg0, (i == 7));
            end
        end
    endtask

    task automatic test_wrap_and_reset();
        exp_t e;
        bit   seen_f;
        bit   seen_wrap;
        logic [7:0] prev_seg1;
        seen_f    = 1'b0;
        seen_wrap = 1'b0;
        prev_seg1 = seg1;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 5; i++) begin
                tick(3'((k + 2) % 8), 1'b1, 1'b0);
                e = exp_q.pop_front();
                total++;
                if ({seg0, seg1, led_vld, chg_pulse} !== {e.seg0, e.seg1, e.led, e.pulse}) begin
                    bad++;
                    $display("FAIL wrap_sb k=%0d cyc=%0d got %h %h %b %b want %h %h %b %b", k, i,
                             seg0, seg1, led_vld, chg_pulse, e.seg0, e.seg1, e.led, e.pulse);
                end
                if (seg1 === 8'h71) seen_f = 1'b1;
                if (prev_seg1 === 8'h71 && seg1 === 8'h03) seen_wrap = 1'b1;
                prev_seg1 = seg1;
            end
        end
        total++;
        if (!(seen_f && seen_wrap)) begin
            bad++;
            $display("FAIL wrap got seen_F=%b seen_F_to_0=%b want 1 1", seen_f, seen_wrap);
        end
        // Reset while a new candidate is settling.
        for (int i = 0; i < 4; i++) begin
            tick(3'd4, 1'b1, (i == 2));
            e = exp_q.pop_front();
            total++;
            if ({seg0, seg1, led_vld, chg_pulse} !== {e.seg0, e.seg1, e.led, e.pulse}) begin
                bad++;
                $display("FAIL rstmid_sb cyc=%0d got %h %h %b %b want %h %h %b %b", i,
                         seg0, seg1, led_vld, chg_pulse, e.seg0, e.seg1, e.led, e.pulse);
            end
            total++;
            if (i >= 2 && {seg0, seg1, led_vld, chg_pulse} !== {8'hFF, 8'h03, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL rstmid cyc=%0d got seg0=%h seg1=%h led=%b pulse=%b want FF 03 0 0",
                         i, seg0, seg1, led_vld, chg_pulse);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [2:0] c;
        logic v;
        c = 3'd0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) c = 3'($urandom_range(0, 7));
            v = ($urandom_range(0, 9) != 0);
            tick(c, v, ($urandom_range(0, 149) == 0));
            e = exp_q.pop_front();
            total++;
            if ({seg0, seg1, led_vld, chg_pulse} !== {e.seg0, e.seg1, e.led, e.pulse}) begin
                bad++;
                $display("FAIL random_sb cyc=%0d got %h %h %b %b want %h %h %b %b", i,
                         seg0, seg1, led_vld, chg_pulse, e.seg0, e.seg1, e.led, e.pulse);
            end
        end
    endtask

    initial begin
        seg_tbl[0]  = 8'h03; seg_tbl[1]  = 8'h9F; seg_tbl[2]  = 8'h25; seg_tbl[3]  = 8'h0D;
        seg_tbl[4]  = 8'h99; seg_tbl[5]  = 8'h49; seg_tbl[6]  = 8'h41; seg_tbl[7]  = 8'h1F;
        seg_tbl[8]  = 8'h01; seg_tbl[9]  = 8'h09; seg_tbl[10] = 8'h11; seg_tbl[11] = 8'hC1;
        seg_tbl[12] = 8'h63; seg_tbl[13] = 8'h85; seg_tbl[14] = 8'h61; seg_tbl[15] = 8'h71;

        test_reset();
        test_clean_commit();
        test_glitch();
        test_mid_settle();
        test_valid_drop();
        test_wrap_and_reset();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_code_seg_display

// File: doc/code_seg_display.md
Name: code_seg_display

Overview:
- Downstream consumer of the 8-to-3 one-hot encoder stage. Takes the 3-bit encoded code plus a valid flag.
- Debounces the code: it must be stable and valid for STABLE_CYCLES consecutive cycles before it is accepted.
- Latches the accepted code and drives it to a 7-segment digit.
- Counts accepted changes (mod 16) on a second hex digit and pulses a change strobe.

Parameters:
- STABLE_CYCLES, 4, consecutive matching valid samples needed to commit a code. Legal range 2..255.
- CNT_W, 8, stability counter width. Must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- code  input  3  encoded index from the encoder stage.
- code_vld  input  1  upstream enable AND input-is-one-hot. Code is ignored when 0.
- seg0  output  8  active-low 7-seg pattern of the held code. Blank when nothing is held.
- seg1  output  8  active-low 7-seg hex pattern of the change count.
- led_vld  output  1  1 once any code has been committed.
- chg_pulse  output  1  one-cycle strobe on each commit that changes the held value.

Behaviour:
- Input stage: code and code_vld are registered into code_q/vld_q. The FSM sees only the registered copies.
- Reset (rst=1 at an edge) applies to all registers, including mid-SETTLE. Values after reset:
  - state=IDLE, held=0, held_vld=0, cnt=0, chg_cnt=0
  - seg0=8'hFF, seg1=SEG_0, led_vld=0, chg_pulse=0
- Segment encoding: bit order [7:0] = a,b,c,d,e,f,g,dp; active-low; dp is always 1.
  - Digits 0..7: 03, 9F, 25, 0D, 99, 49, 41, 1F.
  - Digits 8..F: 01, 09, 11, C1, 63, 85, 61, 71 (hex).
- FSM states: IDLE, SETTLE, HOLD.
- IDLE:
  - vld_q=1 → cand<=code_q, cnt<=1, go SETTLE.
  - Otherwise stay.
- SETTLE:
  - vld_q=0 → abandon candidate; go HOLD if held_vld=1, else IDLE.
  - vld_q=1 and code_q!=cand → cand<=code_q, cnt<=1, stay SETTLE.
  - vld_q=1, code_q==cand, cnt<STABLE_CYCLES-1 → cnt<=cnt+1.
  - vld_q=1, code_q==cand, cnt==STABLE_CYCLES-1 → commit, go HOLD.
- Commit actions:
  - held<=cand, held_vld<=1.
  - If held_vld was 0 or cand!=held: chg_pulse<=1 for exactly one cycle, and chg_cnt<=chg_cnt+1. chg_cnt is 4 bits and wraps from F to 0.
  - If the same value is re-committed: no pulse, no increment.
- HOLD:
  - vld_q=1 and code_q!=held → cand<=code_q, cnt<=1, go SETTLE.
  - vld_q=0, or code_q==held → stay. The display keeps the last value.
- While in SETTLE, seg0 keeps showing held (or blank). There is no intermediate display.
- Latency: a code applied steadily from the edge before cycle 0 is visible on seg0/led_vld/chg_pulse after edge STABLE_CYCLES+1. For example, with STABLE_CYCLES=4 it appears after the 5th edge.
- Outputs are registered. seg0 is a function of held/held_vld, and seg1 is a function of chg_cnt, both registered together at the commit.
- A glitch shorter than STABLE_CYCLES samples never reaches the outputs.
- Changing the code restarts the count at 1, never at 0.

Decomposition:
- Package code_seg_pkg holds:
  - the state enum {IDLE, SETTLE, HOLD};
  - constants SEG_0..SEG_F and SEG_BLANK=8'hFF.
- One natural sub-module, hex_to_seg: a 4-bit to 8-bit combinational decoder. It is instanced twice, for seg0 (with held zero-extended and a blank override) and for seg1.

Test Plan:
- Reset: hold rst=1 for 2 cycles with code=5, code_vld=1 → seg0=FF, seg1=03, led_vld=0, chg_pulse=0 throughout reset.
- Clean commit: code=3 with code_vld=1 held steady (STABLE_CYCLES=4) → after edge 5: seg0=0D, led_vld=1, chg_pulse=1 for one cycle, seg1=9F.
- Glitch rejection: from held=3, apply code=6 for 3 cycles, then back to 3 → seg0 stays 0D, no chg_pulse, seg1 unchanged.
- Mid-settle change: apply code=2 for 2 cycles, then code=7 steady → 7 commits 5 edges after 7 first appears; seg0=1F; code 2 never shown.
- Valid drop: in SETTLE, drop code_vld for 1 cycle → candidate discarded, returns to HOLD, display retained, counter restarts when valid returns.
- Wrap and reset mid-operation: perform 16 distinct-value commits → seg1 goes F(71) then 0(03). Assert rst during SETTLE → IDLE, seg0=FF, no pulse on the following cycle.
